// File: rtl/ipml_sfifo_pkg.sv
// Shared types and helpers for the single-clock FWFT FIFO.
// Output-stage state encoding and count-width helper.
package ipml_sfifo_pkg;

    typedef enum logic [1:0] {
        FWFT_EMPTY = 2'd0,
        FWFT_FETCH = 2'd1,
        FWFT_HOLD  = 2'd2
    } fwft_state_e;

    function automatic int cnt_width(input int depw);
        return depw + 1;
    endfunction

endpackage

// File: rtl/ipml_sfifo_fwft_if.sv
// Write/read/status bundle of the single-clock FIFO.
// master = producer/consumer side, slave = FIFO side.
interface ipml_sfifo_fwft_if #(
    parameter int DW   = 32,
    parameter int DEPW = 10
);

    logic            wr_en;
    logic [DW-1:0]   wr_data;
    logic            wr_full;
    logic            almost_full;
    logic            overflow;
    logic            rd_en;
    logic [DW-1:0]   rd_data;
    logic            rd_valid;
    logic            rd_empty;
    logic            almost_empty;
    logic            underflow;
    logic [DEPW:0]   af_num;
    logic [DEPW:0]   ae_num;
    logic [DEPW:0]   water_level;

    modport master (
        output wr_en,
        output wr_data,
        output rd_en,
        output af_num,
        output ae_num,
        input  wr_full,
        input  almost_full,
        input  overflow,
        input  rd_data,
        input  rd_valid,
        input  rd_empty,
        input  almost_empty,
        input  underflow,
        input  water_level
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  rd_en,
        input  af_num,
        input  ae_num,
        output wr_full,
        output almost_full,
        output overflow,
        output rd_data,
        output rd_valid,
        output rd_empty,
        output almost_empty,
        output underflow,
        output water_level
    );

endinterface

// File: rtl/ipml_sfifo_ram_v2_0.sv
// Simple dual-port RAM, one write and one registered read port.
// Read register holds its value unless re_i is set.
module ipml_sfifo_ram_v2_0 #(
    parameter int               AW       = 10,
    parameter int               DW       = 32,
    parameter logic [DW-1:0]    RST_DATA = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(2**AW)-1];
    logic [DW-1:0] rdata_q;

    // Storage is never cleared; only the read register resets.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= RST_DATA;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ipml_sfifo_fwft_v2_0.sv
// Single-clock FIFO with standard or first-word-fall-through read,
// run-time almost thresholds and sticky overflow/underflow flags.
module ipml_sfifo_fwft_v2_0
    import ipml_sfifo_pkg::*;
#(
    parameter int                    c_DEPTH_WIDTH = 10,
    parameter int                    c_DATA_WIDTH  = 32,
    parameter int                    c_FWFT        = 0,
    parameter logic [c_DATA_WIDTH-1:0] c_RST_DATA  = '0
) (
    input  logic              clk,
    input  logic              rst,
    ipml_sfifo_fwft_if.slave  fifo
);

    localparam int AW = c_DEPTH_WIDTH;
    localparam int CW = cnt_width(c_DEPTH_WIDTH);
    localparam logic [CW-1:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [AW-1:0]           wptr_q, wptr_d;
    logic [AW-1:0]           rptr_q, rptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [CW-1:0]           ram_cnt;
    fwft_state_e             state_q, state_d;
    logic                    wr_full_q;
    logic                    almost_full_q;
    logic                    almost_empty_q;
    logic                    overflow_q;
    logic                    underflow_q;
    logic                    rd_empty_q;
    logic                    rd_valid_q;
    logic                    wr_acc;
    logic                    pop;
    logic                    ram_re;
    logic [c_DATA_WIDTH-1:0] ram_rdata;

    // Acceptance uses the registered flags only.
    assign wr_acc = fifo.wr_en & ~wr_full_q;
    assign pop    = fifo.rd_en & ~rd_empty_q;

    // Words still in RAM, excluding the one shown at the output.
    assign ram_cnt = count_q - CW'(state_q == FWFT_HOLD);

    always_comb begin
        state_d = state_q;
        ram_re  = 1'b0;
        if (c_FWFT != 0) begin
            unique case (state_q)
                FWFT_EMPTY: begin
                    if (wr_acc || (ram_cnt != '0)) begin
                        state_d = FWFT_FETCH;
                    end
                end
                FWFT_FETCH: begin
                    ram_re  = 1'b1;
                    state_d = FWFT_HOLD;
                end
                FWFT_HOLD: begin
                    if (pop) begin
                        if (ram_cnt != '0) begin
                            ram_re = 1'b1;
                        end else begin
                            state_d = FWFT_EMPTY;
                        end
                    end
                end
                default: begin
                    state_d = FWFT_EMPTY;
                end
            endcase
        end else begin
            ram_re = pop;
        end
    end

    always_comb begin
        count_d = count_q;
        wptr_d  = wptr_q + AW'(wr_acc);
        rptr_d  = rptr_q + AW'(ram_re);
        unique case ({wr_acc, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            count_q        <= '0;
            state_q        <= FWFT_EMPTY;
            wr_full_q      <= 1'b0;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            rd_empty_q     <= 1'b1;
            rd_valid_q     <= 1'b0;
        end else begin
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            count_q        <= count_d;
            state_q        <= state_d;
            wr_full_q      <= (count_d == FULL_CNT);
            almost_full_q  <= (count_d >= fifo.af_num);
            almost_empty_q <= (count_d <= fifo.ae_num);
            overflow_q     <= overflow_q
                            | (fifo.wr_en & wr_full_q);
            underflow_q    <= underflow_q
                            | (fifo.rd_en & rd_empty_q);
            if (c_FWFT != 0) begin
                rd_empty_q <= (state_d != FWFT_HOLD);
                rd_valid_q <= (state_d == FWFT_HOLD);
            end else begin
                rd_empty_q <= (count_d == '0);
                rd_valid_q <= pop;
            end
        end
    end

    ipml_sfifo_ram_v2_0 #(
        .AW       (AW),
        .DW       (c_DATA_WIDTH),
        .RST_DATA (c_RST_DATA)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_acc),
        .waddr_i (wptr_q),
        .wdata_i (fifo.wr_data),
        .re_i    (ram_re),
        .raddr_i (rptr_q),
        .rdata_o (ram_rdata)
    );

    assign fifo.wr_full      = wr_full_q;
    assign fifo.almost_full  = almost_full_q;
    assign fifo.overflow     = overflow_q;
    assign fifo.rd_data      = ram_rdata;
    assign fifo.rd_valid     = rd_valid_q;
    assign fifo.rd_empty     = rd_empty_q;
    assign fifo.almost_empty = almost_empty_q;
    assign fifo.underflow    = underflow_q;
    assign fifo.water_level  = count_q;

endmodule

// File: tb/tb_ipml_sfifo_fwft_v2_0.sv
// Bench: standard and FWFT instances driven identically and
// compared every cycle against queue-based reference models.
module tb_ipml_sfifo_fwft_v2_0;

    localparam int DEPW = 4;
    localparam int DW   = 8;
    localparam int N    = 16;
    localparam logic [DW-1:0] RSTD = 8'hC3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ipml_sfifo_fwft_if #(.DW(DW), .DEPW(DEPW)) sif ();
    ipml_sfifo_fwft_if #(.DW(DW), .DEPW(DEPW)) fif ();

    ipml_sfifo_fwft_v2_0 #(
        .c_DEPTH_WIDTH (DEPW),
        .c_DATA_WIDTH  (DW),
        .c_FWFT        (0),
        .c_RST_DATA    (RSTD)
    ) u_std (
        .clk  (clk),
        .rst  (rst),
        .fifo (sif)
    );

    ipml_sfifo_fwft_v2_0 #(
        .c_DEPTH_WIDTH (DEPW),
        .c_DATA_WIDTH  (DW),
        .c_FWFT        (1),
        .c_RST_DATA    (RSTD)
    ) u_fwft (
        .clk  (clk),
        .rst  (rst),
        .fifo (fif)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int af_n   = 14;
    int ae_n   = 2;

    logic [DW-1:0] qs [$];
    logic [DW-1:0] qf [$];
    logic          s_ovf, s_unf, s_af, s_ae, s_rdv;
    logic [DW-1:0] s_rdd;
    logic          f_ovf, f_unf, f_af, f_ae;
    logic          f_vis, f_fetch;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h",
                      tag, got, exp);
    endtask

    task automatic model_reset();
        qs.delete();
        qf.delete();
        s_ovf = 0; s_unf = 0; s_af = 0; s_ae = 1;
        s_rdv = 0; s_rdd = RSTD;
        f_ovf = 0; f_unf = 0; f_af = 0; f_ae = 1;
        f_vis = 0; f_fetch = 0;
    endtask

    // One clock of FIFO behaviour given this cycle's requests.
    task automatic model_step(input logic w,
                              input logic [DW-1:0] d,
                              input logic r);
        logic full, wr, pop;
        int   ram_words;
        // standard read
        full  = (qs.size() == N);
        wr    = w && !full;
        pop   = r && (qs.size() != 0);
        s_ovf = s_ovf | (w && full);
        s_unf = s_unf | (r && (qs.size() == 0));
        s_rdv = pop;
        if (pop) s_rdd = qs.pop_front();
        if (wr) qs.push_back(d);
        s_af = (qs.size() >= af_n);
        s_ae = (qs.size() <= ae_n);
        // first word fall through
        full      = (qf.size() == N);
        wr        = w && !full;
        pop       = r && f_vis;
        ram_words = qf.size() - int'(f_vis);
        f_ovf     = f_ovf | (w && full);
        f_unf     = f_unf | (r && !f_vis);
        if (pop) begin
            void'(qf.pop_front());
            f_vis = (ram_words > 0);
        end else if (f_fetch) begin
            f_vis   = 1;
            f_fetch = 0;
        end else if (!f_vis && (ram_words > 0 || wr)) begin
            f_fetch = 1;
        end
        if (wr) qf.push_back(d);
        f_af = (qf.size() >= af_n);
        f_ae = (qf.size() <= ae_n);
    endtask

    task automatic check_all();
        chk("s_level", sif.water_level, qs.size());
        chk("s_full", sif.wr_full, qs.size() == N);
        chk("s_afull", sif.almost_full, s_af);
        chk("s_aempty", sif.almost_empty, s_ae);
        chk("s_ovf", sif.overflow, s_ovf);
        chk("s_unf", sif.underflow, s_unf);
        chk("s_empty", sif.rd_empty, qs.size() == 0);
        chk("s_valid", sif.rd_valid, s_rdv);
        chk("s_data", sif.rd_data, s_rdd);
        chk("f_level", fif.water_level, qf.size());
        chk("f_full", fif.wr_full, qf.size() == N);
        chk("f_afull", fif.almost_full, f_af);
        chk("f_aempty", fif.almost_empty, f_ae);
        chk("f_ovf", fif.overflow, f_ovf);
        chk("f_unf", fif.underflow, f_unf);
        chk("f_empty", fif.rd_empty, !f_vis);
        chk("f_valid", fif.rd_valid, f_vis);
        if (f_vis) chk("f_data", fif.rd_data, qf[0]);
    endtask

    task automatic cycle(input logic r_st,
                         input logic w,
                         input logic [DW-1:0] d,
                         input logic r);
        rst         = r_st;
        sif.wr_en   = w;
        fif.wr_en   = w;
        sif.wr_data = d;
        fif.wr_data = d;
        sif.rd_en   = r;
        fif.rd_en   = r;
        sif.af_num  = 5'(af_n);
        fif.af_num  = 5'(af_n);
        sif.ae_num  = 5'(ae_n);
        fif.ae_num  = 5'(ae_n);
        if (r_st) model_reset();
        else model_step(w, d, r);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    int p_w [6] = '{90, 10, 50, 70, 30, 100};
    int p_r [6] = '{10, 90, 50, 30, 70, 100};

    initial begin
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("f_rst_data", fif.rd_data, RSTD);
        // fill to full, one rejected write, then drain
        for (int i = 0; i < N; i++) cycle(0, 1, 8'(i), 0);
        cycle(0, 1, 8'hAA, 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < N + 4; i++) cycle(0, 0, 0, 1);
        // read and write together while empty
        cycle(0, 1, 8'h5A, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
        // streaming pops of an 8-word burst
        for (int i = 0; i < 8; i++) cycle(0, 1, 8'h10 + 8'(i), 0);
        for (int i = 0; i < 12; i++) cycle(0, 0, 0, 1);
        // steady level 8 with wrapping pointers
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 1, 8'(i + 40), 0);
        cycle(0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            cycle(0, 1, 8'($urandom), 1);
        // reset with 9 entries held
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) cycle(0, 1, 8'(i + 80), 0);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'(i + 96), 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1);
        // random traffic with moving thresholds
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(31) == 0) begin
                    af_n = $urandom_range(16);
                    ae_n = $urandom_range(16);
                end
                cycle(($urandom_range(199) == 0),
                      ($urandom_range(99) < p_w[s]),
                      8'($urandom),
                      ($urandom_range(99) < p_r[s]));
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
